// File: rtl/regfile.sv
// Architectural register file with per-register ROB rename tags: combinational
// reads, commit write-back, dispatch rename and flush. Optional REGFILE_BYPASS_EN.
module regfile #(
    parameter int REG_NUM    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_val,
    output logic [TAG_WIDTH-1:0]  rs1_rely,
    output logic [DATA_WIDTH-1:0] rs2_val,
    output logic [TAG_WIDTH-1:0]  rs2_rely,
    input  logic                  dispatch_rdy,
    input  logic [4:0]            up_rd,
    input  logic [TAG_WIDTH-1:0]  ROB_next_tag,
    input  logic                  write_rdy,
    input  logic [4:0]            to_rd,
    input  logic [DATA_WIDTH-1:0] write_val,
    input  logic [TAG_WIDTH-1:0]  head_tag,
    input  logic                  clear
);

    logic [DATA_WIDTH-1:0] val_q [REG_NUM];
    logic [TAG_WIDTH-1:0]  tag_q [REG_NUM];

    // NOTE: the arrays are reset element by element because reset must visibly
    // clear every value and tag asynchronously; a plain RAM macro cannot do this.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            // NOTE: later non-blocking assignments to the same element win, which
            // encodes the priority clear > rename > commit tag-clear.
            if (write_rdy && (to_rd != '0)) begin
                val_q[to_rd] <= write_val;
                if (tag_q[to_rd] == head_tag) begin
                    tag_q[to_rd] <= '0;
                end
            end
            if (clear) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag_q[i] <= '0;
                end
            end else if (dispatch_rdy && (up_rd != '0)) begin
                tag_q[up_rd] <= ROB_next_tag;
            end
        end
    end

    // NOTE: outputs get defaults first so every path assigns them and no latch forms.
    always_comb begin
        rs1_val  = '0;
        rs1_rely = '0;
        if (rs1_addr != '0) begin
            rs1_val  = val_q[rs1_addr];
            rs1_rely = tag_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (write_rdy && (to_rd == rs1_addr) && (tag_q[rs1_addr] == head_tag)) begin
                rs1_val  = write_val;
                rs1_rely = '0;
            end
`endif
        end
    end

    always_comb begin
        rs2_val  = '0;
        rs2_rely = '0;
        if (rs2_addr != '0) begin
            rs2_val  = val_q[rs2_addr];
            rs2_rely = tag_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (write_rdy && (to_rd == rs2_addr) && (tag_q[rs2_addr] == head_tag)) begin
                rs2_val  = write_val;
                rs2_rely = '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// against a behavioural register/tag model.
module tb_regfile;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rs1_rely, rs2_rely;
    logic        dispatch_rdy;
    logic [4:0]  up_rd;
    logic [4:0]  ROB_next_tag;
    logic        write_rdy;
    logic [4:0]  to_rd;
    logic [31:0] write_val;
    logic [4:0]  head_tag;
    logic        clear;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    regfile dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val), .rs1_rely(rs1_rely),
        .rs2_val(rs2_val), .rs2_rely(rs2_rely),
        .dispatch_rdy(dispatch_rdy), .up_rd(up_rd), .ROB_next_tag(ROB_next_tag),
        .write_rdy(write_rdy), .to_rd(to_rd), .write_val(write_val),
        .head_tag(head_tag), .clear(clear)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
    endtask

    // Architectural effect of one enabled cycle, from the block's rules.
    task automatic model_cycle();
        logic [4:0] old_tag [32];
        if (!rdy_in) return;
        old_tag = m_tag;
        if (write_rdy && to_rd != 0) begin
            m_val[to_rd] = write_val;
            if (old_tag[to_rd] == head_tag) m_tag[to_rd] = 0;
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) m_tag[i] = 0;
        end else if (dispatch_rdy && up_rd != 0) begin
            m_tag[up_rd] = ROB_next_tag;
        end
    endtask

    function automatic void exp_read(input logic [4:0] a, output logic [31:0] v, output logic [4:0] t);
        v = (a == 0) ? 32'h0 : m_val[a];
        t = (a == 0) ? 5'h0 : m_tag[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && write_rdy && to_rd == a && m_tag[a] == head_tag) begin
            v = write_val;
            t = 0;
        end
`endif
    endfunction

    task automatic idle();
        rdy_in = 1; dispatch_rdy = 0; up_rd = 0; ROB_next_tag = 0;
        write_rdy = 0; to_rd = 0; write_val = 0; head_tag = 0; clear = 0;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] t);
        idle();
        dispatch_rdy = 1; up_rd = rd; ROB_next_tag = t;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst_in = 0;
        idle();
        rs1_addr = 5; rs2_addr = 6;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (rs1_val !== 32'h0 || rs1_rely !== 5'h0) begin errors++; $display("FAIL reset_x5_during: val=%h rely=%0d want 0/0", rs1_val, rs1_rely); end
        rst_in = 1;
        @(posedge clk_in); #1;
        checks++; if (rs1_val !== 32'h0) begin errors++; $display("FAIL reset_x5_val: got %h want 0", rs1_val); end
        checks++; if (rs1_rely !== 5'h0) begin errors++; $display("FAIL reset_x5_rely: got %0d want 0", rs1_rely); end
        checks++; if (rs2_val !== 32'h0 || rs2_rely !== 5'h0) begin errors++; $display("FAIL reset_x6: val=%h rely=%0d want 0/0", rs2_val, rs2_rely); end
    endtask

    task automatic test_rename_commit();
        rename(5, 3);
        rs1_addr = 5; #1;
        checks++; if (rs1_rely !== 5'd3) begin errors++; $display("FAIL rename_x5_rely: got %0d want 3", rs1_rely); end
        write_rdy = 1; to_rd = 5; head_tag = 3; write_val = 32'h1234;
        step(); idle(); #1;
        checks++; if (rs1_val !== 32'h1234) begin errors++; $display("FAIL commit_x5_val: got %h want 1234", rs1_val); end
        checks++; if (rs1_rely !== 5'd0) begin errors++; $display("FAIL commit_x5_rely: got %0d want 0", rs1_rely); end
    endtask

    task automatic test_stale_commit();
        rename(7, 2);
        rename(7, 4);
        write_rdy = 1; to_rd = 7; head_tag = 2; write_val = 32'hAA;
        step(); idle();
        rs1_addr = 7; #1;
        checks++; if (rs1_val !== 32'hAA) begin errors++; $display("FAIL stale_x7_val: got %h want aa", rs1_val); end
        checks++; if (rs1_rely !== 5'd4) begin errors++; $display("FAIL stale_x7_rely: got %0d want 4", rs1_rely); end
    endtask

    task automatic test_same_cycle();
        write_rdy = 1; to_rd = 9; head_tag = 1; write_val = 32'h55;
        dispatch_rdy = 1; up_rd = 9; ROB_next_tag = 6;
        step(); idle();
        rs2_addr = 9; #1;
        checks++; if (rs2_val !== 32'h55 || rs2_rely !== 5'd6) begin errors++; $display("FAIL same_cycle_x9: val=%h rely=%0d want 55/6", rs2_val, rs2_rely); end
        // rs == rd: the dispatching instruction sees the previous producer
        rs1_addr = 9; dispatch_rdy = 1; up_rd = 9; ROB_next_tag = 8; #1;
        checks++; if (rs1_rely !== 5'd6) begin errors++; $display("FAIL pre_rename_read: rely=%0d want 6", rs1_rely); end
        step(); idle(); #1;
        checks++; if (rs1_rely !== 5'd8) begin errors++; $display("FAIL post_rename_read: rely=%0d want 8", rs1_rely); end
    endtask

    task automatic test_clear();
        rename(1, 1); rename(2, 2); rename(3, 3);
        clear = 1; write_rdy = 1; to_rd = 1; write_val = 32'h77; head_tag = 9;
        dispatch_rdy = 1; up_rd = 4; ROB_next_tag = 7;
        step(); idle();
        rs1_addr = 1; rs2_addr = 2; #1;
        checks++; if (rs1_val !== 32'h77 || rs1_rely !== 5'd0) begin errors++; $display("FAIL clear_x1: val=%h rely=%0d want 77/0", rs1_val, rs1_rely); end
        checks++; if (rs2_rely !== 5'd0) begin errors++; $display("FAIL clear_x2_rely: got %0d want 0", rs2_rely); end
        rs1_addr = 3; rs2_addr = 4; #1;
        checks++; if (rs1_rely !== 5'd0) begin errors++; $display("FAIL clear_x3_rely: got %0d want 0", rs1_rely); end
        checks++; if (rs2_rely !== 5'd0) begin errors++; $display("FAIL clear_x4_rely: got %0d want 0", rs2_rely); end
        rs1_addr = 5; #1;
        checks++; if (rs1_val !== 32'h1234) begin errors++; $display("FAIL clear_keeps_x5: got %h want 1234", rs1_val); end
    endtask

    task automatic test_rdy_freeze();
        rename(1, 1); rename(2, 2); rename(3, 3);
        rdy_in = 0; clear = 1; write_rdy = 1; to_rd = 1; write_val = 32'h88; head_tag = 1;
        dispatch_rdy = 1; up_rd = 4; ROB_next_tag = 7;
        rs1_addr = 2; #1;
        checks++; if (rs1_rely !== 5'd2) begin errors++; $display("FAIL frozen_read_live: rely=%0d want 2", rs1_rely); end
        step(); idle();
        rs1_addr = 1; rs2_addr = 3; #1;
        checks++; if (rs1_val !== 32'h77 || rs1_rely !== 5'd1) begin errors++; $display("FAIL frozen_x1: val=%h rely=%0d want 77/1", rs1_val, rs1_rely); end
        checks++; if (rs2_rely !== 5'd3) begin errors++; $display("FAIL frozen_x3_rely: got %0d want 3", rs2_rely); end
        rs2_addr = 4; #1;
        checks++; if (rs2_rely !== 5'd0) begin errors++; $display("FAIL frozen_x4_rely: got %0d want 0", rs2_rely); end
    endtask

    task automatic test_x0();
        dispatch_rdy = 1; up_rd = 0; ROB_next_tag = 5;
        write_rdy = 1; to_rd = 0; write_val = 32'hFF; head_tag = 0;
        rs1_addr = 0; #1;
        checks++; if (rs1_val !== 32'h0 || rs1_rely !== 5'd0) begin errors++; $display("FAIL x0_same_cycle: val=%h rely=%0d want 0/0", rs1_val, rs1_rely); end
        step(); idle(); #1;
        checks++; if (rs1_val !== 32'h0 || rs1_rely !== 5'd0) begin errors++; $display("FAIL x0_after: val=%h rely=%0d want 0/0", rs1_val, rs1_rely); end
    endtask

    task automatic test_bypass();
        logic [31:0] ev;
        logic [4:0]  et;
        rename(8, 3);
        write_rdy = 1; to_rd = 8; head_tag = 3; write_val = 32'h99;
        rs1_addr = 8; #1;
        exp_read(8, ev, et);
        checks++; if (rs1_val !== ev || rs1_rely !== et) begin errors++; $display("FAIL bypass_x8: val=%h rely=%0d want %h/%0d", rs1_val, rs1_rely, ev, et); end
        step(); idle(); #1;
        checks++; if (rs1_val !== 32'h99 || rs1_rely !== 5'd0) begin errors++; $display("FAIL bypass_x8_after: val=%h rely=%0d want 99/0", rs1_val, rs1_rely); end
    endtask

    task automatic test_random();
        logic [31:0] ev1, ev2;
        logic [4:0]  et1, et2;
        for (int n = 0; n < 400; n++) begin
            rdy_in       = ($urandom_range(0, 7) != 0);
            dispatch_rdy = $urandom_range(0, 1);
            up_rd        = $urandom_range(0, 15);
            ROB_next_tag = $urandom_range(1, 16);
            write_rdy    = $urandom_range(0, 1);
            to_rd        = $urandom_range(0, 15);
            write_val    = $urandom;
            head_tag     = $urandom_range(0, 1) ? m_tag[to_rd] : 5'($urandom_range(1, 16));
            clear        = ($urandom_range(0, 19) == 0);
            rs1_addr     = $urandom_range(0, 1) ? to_rd : 5'($urandom_range(0, 15));
            rs2_addr     = $urandom_range(0, 1) ? up_rd : 5'($urandom_range(0, 31));
            #1;
            exp_read(rs1_addr, ev1, et1);
            exp_read(rs2_addr, ev2, et2);
            checks++; if (rs1_val !== ev1 || rs1_rely !== et1) begin errors++; $display("FAIL rand_rs1[%0d] x%0d: val=%h rely=%0d want %h/%0d", n, rs1_addr, rs1_val, rs1_rely, ev1, et1); end
            checks++; if (rs2_val !== ev2 || rs2_rely !== et2) begin errors++; $display("FAIL rand_rs2[%0d] x%0d: val=%h rely=%0d want %h/%0d", n, rs2_addr, rs2_val, rs2_rely, ev2, et2); end
            step();
        end
        idle();
    endtask

    task automatic test_async_reset();
        rename(11, 5); rename(12, 6);
        rs1_addr = 11; rs2_addr = 12; #1;
        checks++; if (rs1_rely !== 5'd5 || rs2_rely !== 5'd6) begin errors++; $display("FAIL pre_reset_tags: %0d/%0d want 5/6", rs1_rely, rs2_rely); end
        #1 rst_in = 0;
        model_reset();
        #1;
        checks++; if (rs1_rely !== 5'd0 || rs2_rely !== 5'd0 || rs1_val !== 32'h0 || rs2_val !== 32'h0) begin errors++; $display("FAIL async_reset_now: rely %0d/%0d val %h/%h want 0", rs1_rely, rs2_rely, rs1_val, rs2_val); end
        dispatch_rdy = 1; up_rd = 11; ROB_next_tag = 9;
        @(posedge clk_in); #1;
        checks++; if (rs1_rely !== 5'd0) begin errors++; $display("FAIL reset_holds: rely=%0d want 0", rs1_rely); end
        idle();
        @(negedge clk_in) rst_in = 1;
        @(posedge clk_in); #1;
        rs1_addr = 5; #1;
        checks++; if (rs1_val !== 32'h0 || rs1_rely !== 5'd0) begin errors++; $display("FAIL after_release_x5: val=%h rely=%0d want 0/0", rs1_val, rs1_rely); end
    endtask

    initial begin
        rs1_addr = 0; rs2_addr = 0;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_clear();
        test_rdy_freeze();
        test_x0();
        test_bypass();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
